cpu_trace_checker: RTL and testbench
====================================

# cpu_trace_checker

Parametrised successor to the single-record format checker in the CPU verification harness. It consumes the simulator trace one ASCII character per cycle and recognises register-write records (`^T@P: $G <= D#`) and memory-write records (`^T@P: *A <= D#`). For every complete record it reports the format, the decoded field values and semantic error flags. Downstream scoreboards consume these outputs directly instead of re-parsing text.

## Interface
- `MAX_TIME_DIGITS`, 4: maximum decimal digits in the time field T (minimum is 1).
- `MAX_GRF_DIGITS`, 4: maximum decimal digits in register number G (minimum is 1).
- `HEX_DIGITS`, 8: exact number of lowercase hex digits in P, A and D.
- `VAL_W`, 14: width of the decimal accumulators; must hold 10^max(digits)−1.
- `PC_MIN`, 32'h0000_3000: lowest legal PC.
- `PC_MAX`, 32'h0000_6ffc: highest legal PC.
- `ADDR_MAX`, 32'h0000_2ffc: highest legal memory address.
- `clk` in 1: clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `char` in 8: ASCII input character, sampled every cycle.
- `format_type` out 2: 2'b01 = register record, 2'b10 = memory record, 2'b00 = no record completed.
- `error_code` out 4: semantic errors of the completed record; valid only while `format_type != 0`.
- `time_val` out VAL_W: decoded T.
- `pc` out 4*HEX_DIGITS: decoded P.
- `target` out 4*HEX_DIGITS: A for memory records; G zero-extended for register records.
- `data` out 4*HEX_DIGITS: decoded D.

## Operation
- FSM states:
  - IDLE
  - TIME: ≥1 digit seen.
  - AT: '@' seen.
  - PC: ≥1 hex digit seen.
  - SP0: ':' seen, spaces allowed.
  - KIND: '$' or '*' seen.
  - TGT: ≥1 digit seen, trailing spaces allowed.
  - LT: '<' seen.
  - EQ: '=' seen, spaces allowed.
  - DATA: ≥1 hex digit seen.
- Grammar: '^', then 1..MAX_TIME_DIGITS decimal digits, '@', exactly HEX_DIGITS hex digits, ':', any number of spaces (0 or more), then the kind character.
  - Register kind: '$' followed by 1..MAX_GRF_DIGITS decimal digits.
  - Memory kind: '*' followed by exactly HEX_DIGITS hex digits.
- After the kind field: any number of spaces, '<', '=', any number of spaces, exactly HEX_DIGITS hex digits, '#'.
- Once a space follows the target field, further target digits are illegal.
- Hex digits are '0'-'9' and 'a'-'f' only. Uppercase characters are illegal.
- '^' in any state clears all counters and accumulators and enters TIME-pending; the character after it must be a digit.
- Any other illegal character, or any digit-count overflow or underflow, returns the FSM to IDLE. No output is produced.
- Field accumulation:
  - Decimal: `acc <= acc*10 + (char-"0")`, truncated to VAL_W bits.
  - Hex: `acc <= {acc, nibble}`.
  - Accumulators are cleared on entry to each field.
- Error bits (evaluated on the accepted '#' using the final field values):
  - [0]: pc[1:0] != 0, or pc < PC_MIN, or pc > PC_MAX.
  - [1]: memory record with addr[1:0] != 0 or addr > ADDR_MAX. Always 0 for register records.
  - [2]: register record with G > 31. Always 0 for memory records.
  - [3]: time_val < the time of the previous accepted record.
- The previous-time register is updated only on accepted records and is cleared to 0 by reset.

## Timing
- Reset values: `format_type` 0, `error_code` 0, `time_val` 0, `pc` 0, `target` 0, `data` 0, FSM state IDLE, previous time 0.
- Latency: on the rising edge that samples an accepted '#', all outputs load together. They are visible in the following cycle.
- `format_type` and `error_code` return to 0 on the next edge, so the completion pulse is exactly one cycle long.
- `time_val`, `pc`, `target` and `data` hold until the next accepted record.
- `reset` takes priority over `char` on the same edge. A record in progress when reset is asserted is discarded.
- '^' immediately following '#' (back-to-back records) is legal. The FSM is in IDLE after '#', so no gap cycle is needed.

## Configuration
- `CPU_TRACE_ERRCHK_EN` defined:
  - `error_code` is computed as specified.
  - The previous-time register exists.
- `CPU_TRACE_ERRCHK_EN` undefined:
  - `error_code` is tied to 4'b0000.
  - Range, alignment and ordering logic and the previous-time register are not synthesised.
  - Format recognition, field outputs and timing are unchanged.

## Test plan
- Drive "^12@00003000: $5 <= 0000000a#" → `format_type`=01 for 1 cycle. `time_val`=12, `pc`=32'h3000, `target`=5, `data`=32'ha, `error_code`=0.
- Drive "^3@00003004:*00000010 <= ffffffff#" → `format_type`=10, `target`=32'h10, `data`=32'hffffffff, `error_code`=0. Then drive "^2@00002ffe: $40<=00000000#" → `format_type`=01, `error_code`=4'b1101.
- Drive "^12345@…" (5 time digits) and "^1@0000300:…" (7 hex digits) → `format_type` stays 0 throughout.
- Drive "^1@00^7@00003000: $0 <= 00000000#" → exactly one completion pulse, with `time_val`=7.
- Assert reset for one edge mid-record at the '<' character, then finish the character stream → no pulse. A following valid record is accepted, and since previous time was cleared to 0, `error_code`[3]=0.
- Build without `CPU_TRACE_ERRCHK_EN` and repeat scenario 2 → identical `format_type` and field values, with `error_code`=0.

Source files
------------

// File: rtl/cpu_trace_checker.sv
// Streaming recogniser for register/memory-write trace records, one ASCII char per cycle.
// Define CPU_TRACE_ERRCHK_EN to build the range/alignment/ordering checks behind error_code.
module cpu_trace_checker #(
  parameter int unsigned MAX_TIME_DIGITS = 4,
  parameter int unsigned MAX_GRF_DIGITS  = 4,
  parameter int unsigned HEX_DIGITS      = 8,
  parameter int unsigned VAL_W           = 14,
  parameter logic [31:0] PC_MIN          = 32'h0000_3000,
  parameter logic [31:0] PC_MAX          = 32'h0000_6ffc,
  parameter logic [31:0] ADDR_MAX        = 32'h0000_2ffc
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              char,
  output logic [1:0]              format_type,
  output logic [3:0]              error_code,
  output logic [VAL_W-1:0]        time_val,
  output logic [4*HEX_DIGITS-1:0] pc,
  output logic [4*HEX_DIGITS-1:0] target,
  output logic [4*HEX_DIGITS-1:0] data
);
  localparam int unsigned DW   = 4 * HEX_DIGITS;
  localparam int unsigned MAXD = (HEX_DIGITS > MAX_TIME_DIGITS)
      ? ((HEX_DIGITS > MAX_GRF_DIGITS) ? HEX_DIGITS : MAX_GRF_DIGITS)
      : ((MAX_TIME_DIGITS > MAX_GRF_DIGITS) ? MAX_TIME_DIGITS : MAX_GRF_DIGITS);
  localparam int unsigned CW   = $clog2(MAXD + 1);

  if (PC_MIN > PC_MAX || PC_MIN[1:0] != 2'b00 || ADDR_MAX[1:0] != 2'b00 || VAL_W < 5) begin : g_cfg_err
    $error("cpu_trace_checker: inconsistent parameter set");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_AT, S_PC, S_SP0, S_KIND, S_TGT, S_LT, S_EQ, S_DATA
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mem_q, mem_d;
  logic             sp_q, sp_d;
  logic [VAL_W-1:0] tacc_q, tacc_d, gacc_q, gacc_d;
  logic [DW-1:0]    pacc_q, pacc_d, aacc_q, aacc_d, dacc_q, dacc_d;
  logic             accept;

  logic [1:0]       format_q;
  logic [VAL_W-1:0] time_q;
  logic [DW-1:0]    pc_q, tgt_q, data_q;

  logic             is_dec, is_hex, tgt_full;
  logic [7:0]       off_dec, off_hex;
  logic [3:0]       nib;
  logic [CW-1:0]    tgt_lim;

  assign is_dec   = (char >= 8'h30) && (char <= 8'h39);
  assign is_hex   = is_dec || ((char >= 8'h61) && (char <= 8'h66));
  assign off_dec  = char - 8'h30;
  assign off_hex  = char - 8'h57;
  assign nib      = is_dec ? off_dec[3:0] : off_hex[3:0];
  assign tgt_lim  = mem_q ? CW'(HEX_DIGITS) : CW'(MAX_GRF_DIGITS);
  // In TGT a register target always has >=1 digit; a memory target needs all of them
  assign tgt_full = mem_q ? (cnt_q == CW'(HEX_DIGITS)) : 1'b1;

  function automatic logic [VAL_W-1:0] dec_acc(input logic [VAL_W-1:0] acc, input logic [3:0] d);
    return VAL_W'(acc * VAL_W'(10)) + VAL_W'(d);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    sp_d    = sp_q;
    tacc_d  = tacc_q;
    gacc_d  = gacc_q;
    pacc_d  = pacc_q;
    aacc_d  = aacc_q;
    dacc_d  = dacc_q;
    accept  = 1'b0;
    if (char == "^") begin
      state_d = S_TIME;
      cnt_d   = '0;
      sp_d    = 1'b0;
      tacc_d  = '0;
      gacc_d  = '0;
      pacc_d  = '0;
      aacc_d  = '0;
      dacc_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_TIME:
          if (is_dec && cnt_q < CW'(MAX_TIME_DIGITS)) begin
            tacc_d = dec_acc(tacc_q, nib);
            cnt_d  = cnt_q + CW'(1);
          end else if (char == "@" && cnt_q != '0) begin
            state_d = S_AT;
            cnt_d   = '0;
            pacc_d  = '0;
          end else state_d = S_IDLE;
        S_AT, S_PC:
          if (is_hex && cnt_q < CW'(HEX_DIGITS)) begin
            pacc_d  = {pacc_q[DW-5:0], nib};
            cnt_d   = cnt_q + CW'(1);
            state_d = S_PC;
          end else if (char == ":" && cnt_q == CW'(HEX_DIGITS)) state_d = S_SP0;
          else state_d = S_IDLE;
        S_SP0:
          if (char == "$" || char == "*") begin
            state_d = S_KIND;
            mem_d   = (char == "*");
            cnt_d   = '0;
            sp_d    = 1'b0;
            gacc_d  = '0;
            aacc_d  = '0;
          end else if (char != " ") state_d = S_IDLE;
        S_KIND, S_TGT:
          if (!sp_q && cnt_q < tgt_lim && (mem_q ? is_hex : is_dec)) begin
            if (mem_q) aacc_d = {aacc_q[DW-5:0], nib};
            else       gacc_d = dec_acc(gacc_q, nib);
            cnt_d   = cnt_q + CW'(1);
            state_d = S_TGT;
          end else if (state_q == S_TGT && tgt_full && char == " ") sp_d = 1'b1;
          else if (state_q == S_TGT && tgt_full && char == "<") state_d = S_LT;
          else state_d = S_IDLE;
        S_LT:
          state_d = (char == "=") ? S_EQ : S_IDLE;
        S_EQ:
          if (is_hex) begin
            dacc_d  = DW'(nib);
            cnt_d   = CW'(1);
            state_d = S_DATA;
          end else if (char != " ") state_d = S_IDLE;
        S_DATA:
          if (is_hex && cnt_q < CW'(HEX_DIGITS)) begin
            dacc_d = {dacc_q[DW-5:0], nib};
            cnt_d  = cnt_q + CW'(1);
          end else begin
            accept  = (char == "#") && (cnt_q == CW'(HEX_DIGITS));
            state_d = S_IDLE;
          end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mem_q    <= 1'b0;
      sp_q     <= 1'b0;
      tacc_q   <= '0;
      gacc_q   <= '0;
      pacc_q   <= '0;
      aacc_q   <= '0;
      dacc_q   <= '0;
      format_q <= '0;
      time_q   <= '0;
      pc_q     <= '0;
      tgt_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      sp_q     <= sp_d;
      tacc_q   <= tacc_d;
      gacc_q   <= gacc_d;
      pacc_q   <= pacc_d;
      aacc_q   <= aacc_d;
      dacc_q   <= dacc_d;
      format_q <= accept ? (mem_q ? 2'b10 : 2'b01) : 2'b00;
      if (accept) begin
        time_q <= tacc_q;
        pc_q   <= pacc_q;
        tgt_q  <= mem_q ? aacc_q : DW'(gacc_q);
        data_q <= dacc_q;
      end
    end
  end

`ifdef CPU_TRACE_ERRCHK_EN
  logic [3:0]       err_d, err_q;
  logic [VAL_W-1:0] prev_q;

  always_comb begin
    err_d    = '0;
    err_d[0] = (pacc_q[1:0] != 2'b00) || (pacc_q < DW'(PC_MIN)) || (pacc_q > DW'(PC_MAX));
    err_d[1] = mem_q && ((aacc_q[1:0] != 2'b00) || (aacc_q > DW'(ADDR_MAX)));
    err_d[2] = !mem_q && (gacc_q > VAL_W'(31));
    err_d[3] = tacc_q < prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q  <= '0;
      prev_q <= '0;
    end else begin
      err_q <= accept ? err_d : '0;
      if (accept) prev_q <= tacc_q;
    end
  end

  assign error_code = err_q;
`else
  assign error_code = '0;
`endif

  assign format_type = format_q;
  assign time_val    = time_q;
  assign pc          = pc_q;
  assign target      = tgt_q;
  assign data        = data_q;
endmodule

// File: tb/tb_cpu_trace_checker.sv
// Randomised and directed bench for cpu_trace_checker against a string-level parser model.
module tb_cpu_trace_checker;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char;
  logic [1:0]  format_type;
  logic [3:0]  error_code;
  logic [13:0] time_val;
  logic [31:0] pc, target, data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

`ifdef CPU_TRACE_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_trace_checker #(
    .MAX_TIME_DIGITS(4), .MAX_GRF_DIGITS(4), .HEX_DIGITS(8), .VAL_W(14),
    .PC_MIN(32'h0000_3000), .PC_MAX(32'h0000_6ffc), .ADDR_MAX(32'h0000_2ffc)
  ) dut (
    .clk(clk), .reset(reset), .char(char), .format_type(format_type),
    .error_code(error_code), .time_val(time_val), .pc(pc), .target(target), .data(data)
  );

  // Reference model state
  bit               m_active;
  byte unsigned     m_q[$];
  int unsigned      m_prev;
  logic [13:0]      m_time;
  logic [31:0]      m_pc, m_tgt, m_data;
  logic [1:0]       m_fmt, m_fmt_l, o_fmt;
  logic [3:0]       m_err, m_err_l, o_err;
  int unsigned      cyc, o_np, m_np;
  longint unsigned  o_pos, m_pos;

  function automatic bit isdec(input byte unsigned b);
    return b >= 8'h30 && b <= 8'h39;
  endfunction

  function automatic bit ishex(input byte unsigned b);
    return isdec(b) || (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic int hexrun(input byte unsigned q[$], inout int i, output longint unsigned v);
    int n = 0;
    v = 0;
    while (i < q.size() && ishex(q[i])) begin
      v = v * 16 + (isdec(q[i]) ? q[i] - 8'h30 : q[i] - 8'h57);
      n++; i++;
    end
    return n;
  endfunction

  function automatic int decrun(input byte unsigned q[$], inout int i, output longint unsigned v);
    int n = 0;
    v = 0;
    while (i < q.size() && isdec(q[i])) begin
      v = v * 10 + (q[i] - 8'h30);
      n++; i++;
    end
    return n;
  endfunction

  // Parses the body between '^' and '#'.
  function automatic bit parse(input byte unsigned q[$], output bit mem, output int unsigned t,
                               output logic [31:0] p, output logic [31:0] tg, output logic [31:0] d);
    int i = 0;
    int n;
    longint unsigned v;
    mem = 0; t = 0; p = 0; tg = 0; d = 0;
    n = decrun(q, i, v);
    if (n < 1 || n > 4) return 0;
    t = int'(v % 16384);
    if (i >= q.size() || q[i] != "@") return 0;
    i++;
    if (hexrun(q, i, v) != 8) return 0;
    p = v[31:0];
    if (i >= q.size() || q[i] != ":") return 0;
    i++;
    while (i < q.size() && q[i] == " ") i++;
    if (i >= q.size()) return 0;
    if (q[i] == "*") begin
      mem = 1; i++;
      if (hexrun(q, i, v) != 8) return 0;
      tg = v[31:0];
    end else if (q[i] == "$") begin
      i++;
      n = decrun(q, i, v);
      if (n < 1 || n > 4) return 0;
      tg = v[31:0];
    end else return 0;
    while (i < q.size() && q[i] == " ") i++;
    if (i + 1 >= q.size() || q[i] != "<" || q[i+1] != "=") return 0;
    i += 2;
    while (i < q.size() && q[i] == " ") i++;
    if (hexrun(q, i, v) != 8) return 0;
    d = v[31:0];
    return i == q.size();
  endfunction

  task automatic drive_char(input byte unsigned c, input bit r);
    bit mem;
    int unsigned t;
    logic [31:0] p, tg, d;
    char  = c;
    reset = r;
    @(posedge clk);
    m_fmt = 2'b00;
    m_err = 4'b0000;
    if (r) begin
      m_active = 0; m_q.delete(); m_prev = 0;
      m_time = '0; m_pc = '0; m_tgt = '0; m_data = '0;
    end else if (c == "^") begin
      m_active = 1; m_q.delete();
    end else if (m_active) begin
      if (c == "#") begin
        m_active = 0;
        if (parse(m_q, mem, t, p, tg, d)) begin
          m_fmt = mem ? 2'b10 : 2'b01;
          if (ERRCHK) begin
            m_err[0] = (p % 4 != 0) || (p < 32'h3000) || (p > 32'h6ffc);
            m_err[1] = mem && ((tg % 4 != 0) || (tg > 32'h2ffc));
            m_err[2] = !mem && (tg > 31);
            m_err[3] = t < m_prev;
          end
          m_prev = t; m_time = 14'(t); m_pc = p; m_tgt = tg; m_data = d;
        end
      end else m_q.push_back(c);
    end
    #1;
    cyc++;
    if (format_type !== 2'b00) begin
      o_np++; o_pos += cyc; o_fmt = format_type; o_err = error_code;
    end
    if (m_fmt != 2'b00) begin
      m_np++; m_pos += cyc; m_fmt_l = m_fmt; m_err_l = m_err;
    end
  endtask

  task automatic drive_str(input string s);
    for (int i = 0; i < s.len(); i++) drive_char(s[i], 1'b0);
  endtask

  task automatic clear_obs();
    o_np = 0; m_np = 0; o_pos = 0; m_pos = 0;
    o_fmt = 'x; o_err = 'x; m_fmt_l = 'x; m_err_l = 'x;
  endtask

  task automatic test_reset();
    clear_obs();
    drive_char("^", 1'b1);
    drive_char("1", 1'b1);
    n_cmp++;
    if ({format_type, error_code} !== 6'd0) begin
      n_bad++; $display("FAIL reset_flags: got fmt=%b err=%b, want 00/0000", format_type, error_code);
    end
    n_cmp++;
    if ({time_val, pc, target, data} !== '0) begin
      n_bad++; $display("FAIL reset_fields: got t=%0d pc=%h tgt=%h d=%h, want all 0", time_val, pc, target, data);
    end
  endtask

  task automatic test_reg_record();
    clear_obs();
    drive_str("^12@00003000: $5 <= 0000000a# ");
    n_cmp++;
    if (o_np !== m_np || o_pos !== m_pos) begin
      n_bad++; $display("FAIL reg_pulse: got %0d pulses at %0d, want %0d at %0d", o_np, o_pos, m_np, m_pos);
    end
    n_cmp++;
    if ({o_fmt, o_err} !== {2'b01, 4'b0000}) begin
      n_bad++; $display("FAIL reg_flags: got fmt=%b err=%b, want 01/0000", o_fmt, o_err);
    end
    n_cmp++;
    if ({time_val, pc, target, data} !== {14'd12, 32'h3000, 32'd5, 32'ha}) begin
      n_bad++; $display("FAIL reg_fields: got t=%0d pc=%h tgt=%h d=%h, want 12/3000/5/a", time_val, pc, target, data);
    end
  endtask

  task automatic test_mem_and_errors();
    clear_obs();
    drive_str("^3@00003004:*00000010 <= ffffffff# ");
    n_cmp++;
    if (o_np !== 1 || {o_fmt, o_err} !== {2'b10, 4'b0000}) begin
      n_bad++; $display("FAIL mem_flags: got %0d pulses fmt=%b err=%b, want 1/10/0000", o_np, o_fmt, o_err);
    end
    n_cmp++;
    if ({time_val, pc, target, data} !== {14'd3, 32'h3004, 32'h10, 32'hffffffff}) begin
      n_bad++; $display("FAIL mem_fields: got t=%0d pc=%h tgt=%h d=%h, want 3/3004/10/ffffffff", time_val, pc, target, data);
    end
    clear_obs();
    drive_str("^2@00002ffe: $40<=00000000# ");
    n_cmp++;
    if ({o_fmt, o_err} !== {2'b01, (ERRCHK ? 4'b1101 : 4'b0000)}) begin
      n_bad++; $display("FAIL err_flags: got fmt=%b err=%b, want 01/%b", o_fmt, o_err, ERRCHK ? 4'b1101 : 4'b0000);
    end
    n_cmp++;
    if ({time_val, pc, target, data} !== {m_time, m_pc, m_tgt, m_data}) begin
      n_bad++; $display("FAIL err_fields: got t=%0d pc=%h tgt=%h d=%h, want %0d/%h/%h/%h",
                        time_val, pc, target, data, m_time, m_pc, m_tgt, m_data);
    end
  endtask

  task automatic test_overflow();
    clear_obs();
    drive_str("^12345@00003000: $1 <= 00000001# ");
    drive_str("^1@0000300: $1 <= 00000001# ");
    drive_str("^1@00003000: $1 <= 0000000A# ");
    n_cmp++;
    if (o_np !== 0) begin
      n_bad++; $display("FAIL overflow_pulse: got %0d pulses, want 0", o_np);
    end
    n_cmp++;
    if ({time_val, pc, target, data} !== {m_time, m_pc, m_tgt, m_data}) begin
      n_bad++; $display("FAIL overflow_hold: got t=%0d pc=%h tgt=%h d=%h, want %0d/%h/%h/%h",
                        time_val, pc, target, data, m_time, m_pc, m_tgt, m_data);
    end
  endtask

  task automatic test_restart();
    clear_obs();
    drive_str("^1@00^7@00003000: $0 <= 00000000# ");
    n_cmp++;
    if (o_np !== 1 || time_val !== 14'd7) begin
      n_bad++; $display("FAIL restart: got %0d pulses t=%0d, want 1 pulse t=7", o_np, time_val);
    end
  endtask

  task automatic test_reset_midrecord();
    clear_obs();
    drive_str("^5@00003000: $1 ");
    drive_char("<", 1'b1);
    drive_str("= 00000001# ");
    n_cmp++;
    if (o_np !== 0) begin
      n_bad++; $display("FAIL reset_mid_pulse: got %0d pulses, want 0", o_np);
    end
    clear_obs();
    drive_str("^1@00003000: $1 <= 00000001# ");
    n_cmp++;
    if (o_np !== 1 || o_err !== 4'b0000 || o_fmt !== 2'b01) begin
      n_bad++; $display("FAIL reset_mid_next: got %0d pulses fmt=%b err=%b, want 1/01/0000", o_np, o_fmt, o_err);
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    drive_str("^20@00003008:*00000100<=12345678#^21@0000300c: $31 <=  deadbeef#x");
    n_cmp++;
    if (o_np !== m_np || o_pos !== m_pos || m_np !== 2) begin
      n_bad++; $display("FAIL b2b_pulses: got %0d at %0d, want 2 at %0d", o_np, o_pos, m_pos);
    end
    n_cmp++;
    if ({o_fmt, o_err, time_val, pc, target, data} !== {m_fmt_l, m_err_l, m_time, m_pc, m_tgt, m_data}) begin
      n_bad++; $display("FAIL b2b_last: got fmt=%b err=%b t=%0d tgt=%h d=%h, want %b/%b/%0d/%h/%h",
                        o_fmt, o_err, time_val, target, data, m_fmt_l, m_err_l, m_time, m_tgt, m_data);
    end
  endtask

  function automatic string sp();
    case ($urandom_range(0, 2))
      0:       return "";
      1:       return " ";
      default: return "  ";
    endcase
  endfunction

  function automatic logic [31:0] pick_addr(input logic [31:0] lo, input logic [31:0] hi);
    case ($urandom_range(0, 4))
      0:       return lo;
      1:       return hi;
      2:       return hi + 32'd4;
      3:       return lo + ($urandom_range(0, 4095) << 2);
      default: return $urandom;
    endcase
  endfunction

  function automatic string gen_rec();
    int unsigned mode = $urandom_range(0, 11);
    logic [31:0] p = pick_addr(32'h3000, 32'h6ffc);
    logic [31:0] a = pick_addr(32'h0, 32'h2ffc);
    logic [31:0] d = $urandom;
    string ts, ps, ks, ds;
    ts = $sformatf("%0d", (mode == 5) ? $urandom_range(10000, 99999) : $urandom_range(0, 9999));
    ps = (mode == 6) ? $sformatf("%07h", p[27:0]) : $sformatf("%08h", p);
    if ($urandom_range(0, 1) == 1)
      ks = $sformatf("*%08h", a + ($urandom_range(0, 7) == 0 ? 32'd2 : 32'd0));
    else if (mode == 7)
      ks = $sformatf("$%0d", $urandom_range(10000, 20000));
    else if (mode == 9)
      ks = "$1 2";
    else
      ks = $sformatf("$%0d", ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9999) : $urandom_range(0, 40));
    ds = (mode == 8) ? "0000000A" : $sformatf("%08h", d);
    return $sformatf("^%s@%s:%s%s%s<=%s%s#", ts, ps, sp(), ks, sp(), sp(), ds);
  endfunction

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      clear_obs();
      drive_str(gen_rec());
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) drive_char($urandom_range(0, 1) ? " " : "x", 1'b0);
      drive_char(" ", 1'b0);
      n_cmp++;
      if (o_np !== m_np || o_pos !== m_pos) begin
        n_bad++; $display("FAIL rand_pulse[%0d]: got %0d at %0d, want %0d at %0d", k, o_np, o_pos, m_np, m_pos);
      end
      if (m_np != 0) begin
        n_cmp++;
        if ({o_fmt, o_err} !== {m_fmt_l, m_err_l}) begin
          n_bad++; $display("FAIL rand_flags[%0d]: got fmt=%b err=%b, want %b/%b", k, o_fmt, o_err, m_fmt_l, m_err_l);
        end
      end
      n_cmp++;
      if ({time_val, pc, target, data} !== {m_time, m_pc, m_tgt, m_data}) begin
        n_bad++; $display("FAIL rand_fields[%0d]: got t=%0d pc=%h tgt=%h d=%h, want %0d/%h/%h/%h",
                          k, time_val, pc, target, data, m_time, m_pc, m_tgt, m_data);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    char  = 8'h00;
    cyc   = 0;
    test_reset();
    test_reg_record();
    test_mem_and_errors();
    test_overflow();
    test_restart();
    test_reset_midrecord();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got time %0t want < 2000000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
